mux8_rr_arbiter: RTL

//  Round-robin arbiter and sequencer for the shared 8:1 32-bit source mux of the SoC bus.
//  Up to 8 requesters compete for the mux. The block grants one owner at a time and drives
//  the mux select. A tenure limit stops any owner from starving the others.

---
 rtl/mux8_rr_arbiter_if.sv | 25 ++
 rtl/mux8_rr_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/mux8_rr_arbiter_if.sv
// Bus between requesting masters and the 8:1 source-mux arbiter.
//   req[7:0]     request levels, bit i = requester i
//   release_req  1-cycle pulse ending the current owner's tenure
//   grant[7:0]   registered one-hot grant, zero when idle
//   sel[2:0]     mux select, index of the current (or last) owner
//   busy         a grant is active
//   timeout      1-cycle pulse when a tenure is cut by the hold limit
interface mux8_rr_arbiter_if;
  logic [7:0] req;
  logic       release_req;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       busy;
  logic       timeout;

  modport master (
    output req, release_req,
    input  grant, sel, busy, timeout
  );

  modport slave (
    input  req, release_req,
    output grant, sel, busy, timeout
  );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the select of the shared 8:1 32-bit source mux.
//   clk    system clock, rising edge
//   rst_n  synchronous reset, active low
//   bus    slave side of mux8_rr_arbiter_if (req/release_req in,
//          grant/sel/busy/timeout out, all outputs registered)
module mux8_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mux8_rr_arbiter_if.slave         bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [7:0]       grant_q, grant_d;
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       last_q, last_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             timeout_q, timeout_d;

  logic [7:0] own_oh;
  logic [7:0] others;
  logic       cut;
  logic       tenure_end;
  logic [2:0] pick_idx;

  // First set bit of v searching circularly upward from last+1; last itself
  // is checked at k=8 (3'(8) wraps to 0), giving it the lowest priority.
  function automatic logic [2:0] pick(input logic [7:0] v, input logic [2:0] last);
    logic [2:0] idx;
    pick = last;
    for (int unsigned k = 8; k >= 1; k--) begin
      idx = last + 3'(k);
      if (v[idx]) pick = idx;
    end
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      sel_q     <= '0;
      last_q    <= '1;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    sel_d      = sel_q;
    last_d     = last_q;
    hold_d     = hold_q;
    timeout_d  = 1'b0;
    own_oh     = 8'b1 << sel_q;
    others     = bus.req & ~own_oh;
    cut        = (MAX_HOLD != 0) && (hold_q == CNT_W'(MAX_HOLD - 1)) && (others != '0);
    tenure_end = !bus.req[sel_q] || bus.release_req || cut;
    pick_idx   = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.req != '0) begin
          pick_idx = pick(bus.req, last_q);
          grant_d  = 8'b1 << pick_idx;
          sel_d    = pick_idx;
          last_d   = pick_idx;
          hold_d   = '0;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if (MAX_HOLD != 0 && hold_q != CNT_W'(MAX_HOLD)) hold_d = hold_q + 1'b1;
        if (tenure_end) begin
          timeout_d = cut && bus.req[sel_q] && !bus.release_req;
          hold_d    = '0;
          if (others != '0) begin
            pick_idx = pick(others, last_q);
            grant_d  = 8'b1 << pick_idx;
            sel_d    = pick_idx;
            last_d   = pick_idx;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.grant   = grant_q;
    bus.sel     = sel_q;
    bus.busy    = (state_q == GRANT);
    bus.timeout = timeout_q;
  end

endmodule
